rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream data channel.
- Sits between four per-lane source FIFOs and a single shared consumer, for example a serializer or output FIFO.
- Grants one lane at a time and forwards that lane's data under a valid/ready handshake.
- Limits each grant to a bounded burst so that no lane starves the others.

Parameters:
- DATA_W, 8, width of each lane's data word.
- MAX_BURST, 4, maximum beats transferred per grant. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  per-lane request: lane i has a word available on its data_in slice.
- data_in  input  4*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- out_ready  input  1  downstream can accept a word this cycle.
- out_valid  output  1  out_data holds a valid word this cycle.
- out_data  output  DATA_W  word from the currently granted lane.
- pop  output  4  one-hot: lane i's word was consumed this cycle, so the source advances.
- grant  output  4  one-hot registered grant; 0 when idle.
- busy  output  1  high while in state GRANT.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, grant = 4'b0000, last = 3 (so lane 0 has top priority after reset), beat count = 0.
  - All outputs low; out_data = 0.
- States: IDLE, GRANT.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select the first lane with req set, searching last+1, last+2, last+3, last (mod 4).
  - On the next edge: grant = one-hot of that lane, count = 0, state = GRANT.
  - No beats are transferred in IDLE.
- GRANT (granted lane g):
  - Outputs:
    - out_valid = req[g].
    - out_data = data_in slice of lane g.
    - pop[g] = out_valid & out_ready; every other pop bit is 0.
  - A beat is a cycle with out_valid & out_ready. On each beat, count increments.
  - Release to IDLE on the next edge when either:
    - req[g] == 0 (no beat that cycle), or
    - a beat occurs with count == MAX_BURST-1.
  - On release: last = g, grant = 0, count = 0.
  - Otherwise stay in GRANT.
  - out_ready low with req[g] high means hold: no beat, count unchanged, no timeout.
- Combinational paths:
  - out_valid, out_data and pop depend combinationally on req, data_in and out_ready, gated by the registered grant.
  - Sources must not combinationally derive req from pop.
- Timing:
  - Arbitration latency: req rises in cycle n with the arbiter in IDLE; grant is visible in cycle n+1; the first beat is possible in cycle n+1.
  - Every release costs exactly one IDLE bubble cycle before the next grant, even if other lanes are requesting.
- Fairness: with all four lanes continuously requesting and out_ready = 1, the grant order is 0,1,2,3,0,… Each grant carries MAX_BURST beats followed by one bubble.
- Requests arriving during GRANT are ignored until the next IDLE cycle; no preemption.
- req[g] dropping mid-burst:
  - Ends the grant.
  - A later re-assertion by the same lane competes normally, and that lane is now lowest priority.
- Reset asserted mid-burst:
  - Immediately clears grant and pop.
  - No partial-burst state survives.
  - After deassertion, arbitration restarts with lane 0 as top priority.
- count is 4 bits and never exceeds MAX_BURST-1.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert reset during a GRANT of lane 1 at beat 2.
  - Required: grant, pop and out_valid go to 0 immediately, without waiting for a clock edge.
  - After release, with req = 4'b1010, the first grant is lane 1 (search starts from lane 0).
- Single lane streaming:
  - Stimulus: req = 4'b0100, out_ready = 1, data_in lane 2 = 8'hA5, held for 12 cycles.
  - Required: grant = 4'b0100; four beats with pop = 4'b0100 and out_data = 8'hA5; one bubble; repeat. Total 8 pops in 10 cycles after the first grant.
- Full contention:
  - Stimulus: req = 4'b1111, out_ready = 1.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles with a 1-cycle gap.
- Backpressure:
  - Stimulus: lane 0 granted, out_ready = 0 for 5 cycles, then 1.
  - Required: out_valid = 1 and pop = 0 while stalled, count frozen; afterwards exactly 4 beats, then release.
- Early drop:
  - Stimulus: lane 3 granted, req[3] falls after 2 beats, req[0] held high.
  - Required: release the next cycle, one IDLE bubble, then grant = 4'b0001; last = 3.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-lane round-robin arbiter with bounded bursts, forwarding the granted lane's
// data to a single valid/ready consumer.
module rr_arbiter4 #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   data_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [3:0]            pop,
  output logic [3:0]            grant,
  output logic                  busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] COUNT_LAST = 4'(MAX_BURST - 1);

  state_t      state_reg, state_next;
  logic [3:0]  grant_reg, grant_next;
  logic [1:0]  last_reg, last_next;
  logic [3:0]  count_reg, count_next;

  logic [DATA_W-1:0] lane_data [4];
  logic [1:0]        cand_idx  [4];
  logic [1:0]        g_idx;
  logic [1:0]        pick_idx;
  logic              pick_found;
  logic              beat;

  // cand_idx[k] is the (k+1)-th lane after the last served one, wrapping mod 4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_data[gi] = data_in[gi*DATA_W +: DATA_W];
      assign cand_idx[gi]  = last_reg + 2'(gi + 1);
    end
  endgenerate

  always_comb begin
    g_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_reg[i]) g_idx = 2'(i);
    end
  end

  always_comb begin
    pick_idx   = last_reg;
    pick_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!pick_found && req[cand_idx[k]]) begin
        pick_idx   = cand_idx[k];
        pick_found = 1'b1;
      end
    end
  end

  assign busy      = (state_reg == GRANT);
  assign grant     = grant_reg;
  assign out_valid = busy & req[g_idx];
  assign out_data  = busy ? lane_data[g_idx] : '0;
  assign beat      = out_valid & out_ready;
  assign pop       = grant_reg & {4{beat}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= 4'b0000;
      last_reg  <= 2'd3;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          grant_next = 4'b0001 << pick_idx;
          count_next = 4'd0;
        end
      end
      GRANT: begin
        // A dropped request ends the grant without a beat; a stalled one just holds.
        if (!req[g_idx] || (beat && count_reg == COUNT_LAST)) begin
          state_next = IDLE;
          grant_next = 4'b0000;
          count_next = 4'd0;
          last_next  = g_idx;
        end else if (beat) begin
          count_next = count_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: a cycle model pushes expected outputs as each
// cycle's stimulus is driven; they are popped and compared mid-cycle.
module tb_rr_arbiter4;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  pop;
  logic [3:0]  grant;
  logic        busy;

  rr_arbiter4 #(.DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pop       (pop),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic       valid;
    logic [7:0] data;
    logic [3:0] pop;
    logic       busy;
  } exp_t;

  exp_t       exp_q [$];
  logic [3:0] seq_q [$];
  int n_cmp = 0;
  int n_err = 0;

  bit m_busy;
  int m_g, m_last, m_count;

  bit         win_en = 0;
  int         win_pops = 0;
  bit         seq_en = 0;
  logic [3:0] prev_grant = 4'b0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_g     = 0;
    m_last  = 3;
    m_count = 0;
  endtask

  task automatic model_out(output exp_t e);
    e = '0;
    if (m_busy) begin
      e.busy  = 1'b1;
      e.grant = 4'b0001 << m_g;
      e.valid = req[m_g];
      e.data  = data_in[m_g*8 +: 8];
      e.pop   = (e.valid && out_ready) ? e.grant : 4'b0000;
    end
  endtask

  task automatic model_step();
    bit found;
    if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && req[(m_last + k) % 4]) begin
          found   = 1;
          m_g     = (m_last + k) % 4;
          m_busy  = 1;
          m_count = 0;
        end
      end
    end else if (!req[m_g] || (out_ready && m_count == MAXB - 1)) begin
      m_last  = m_g;
      m_busy  = 0;
      m_count = 0;
    end else if (out_ready) begin
      m_count++;
    end
  endtask

  task automatic compare();
    exp_t e;
    e = exp_q.pop_front();
    check_eq("grant", 32'(grant), 32'(e.grant));
    check_eq("out_valid", 32'(out_valid), 32'(e.valid));
    check_eq("pop", 32'(pop), 32'(e.pop));
    check_eq("busy", 32'(busy), 32'(e.busy));
    if (e.valid) check_eq("out_data", 32'(out_data), 32'(e.data));
    if (pop != 4'b0000) begin
      $display("beat t=%0t pop=%b data=%02h", $time, pop, out_data);
      if (win_en) win_pops++;
    end
    if (seq_en && grant != 4'b0000 && grant != prev_grant) seq_q.push_back(grant);
    prev_grant = grant;
  endtask

  // One clock cycle: drive, predict, compare mid-cycle, advance model at the edge.
  task automatic step(input logic [3:0] r, input logic [31:0] d, input logic rdy);
    exp_t e;
    req       = r;
    data_in   = d;
    out_ready = rdy;
    model_out(e);
    exp_q.push_back(e);
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; req = 4'b0000; data_in = '0; out_ready = 1'b0;
    model_reset();
    #2;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_pop", 32'(pop), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_data", 32'(out_data), 32'h0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Full contention: expect 0,1,2,3,0 with one bubble between grants.
    seq_en = 1;
    for (int i = 0; i < 25; i++) step(4'b1111, $urandom, 1'b1);
    seq_en = 0;
    check_eq("seq_len", 32'(seq_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < seq_q.size()) check_eq("seq_grant", 32'(seq_q[i]), 32'(exp_seq[i]));
    end
    step(4'b0000, '0, 1'b1);

    // Single lane streaming on lane 2.
    step(4'b0100, 32'h00A5_0000, 1'b1);
    win_en = 1; win_pops = 0;
    for (int i = 0; i < 10; i++) step(4'b0100, 32'h00A5_0000, 1'b1);
    win_en = 0;
    check_eq("single_pops", 32'(win_pops), 32'd8);
    step(4'b0100, 32'h00A5_0000, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Backpressure on lane 0.
    step(4'b0001, 32'h0000_003C, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0001, 32'h0000_003C, 1'b0);
    win_en = 1; win_pops = 0;
    for (int i = 0; i < 4; i++) step(4'b0001, 32'h0000_0040 + 32'(i), 1'b1);
    win_en = 0;
    check_eq("bp_pops", 32'(win_pops), 32'd4);
    check_eq("bp_release", 32'(busy), 32'h0);
    step(4'b0000, '0, 1'b1);

    // Early drop on lane 3 with lane 0 waiting.
    step(4'b1001, 32'h7700_0011, 1'b1);
    step(4'b1001, 32'h7800_0011, 1'b1);
    step(4'b1001, 32'h7900_0011, 1'b1);
    step(4'b0001, 32'h0000_0012, 1'b1);
    step(4'b0001, 32'h0000_0013, 1'b1);
    check_eq("drop_regrant", 32'(grant), 32'h1);
    for (int i = 0; i < 5; i++) step(4'b0001, 32'h0000_0020 + 32'(i), 1'b1);
    step(4'b0000, '0, 1'b1);

    // Reset mid-burst on lane 1 at beat 2.
    step(4'b0010, 32'h0000_5500, 1'b1);
    step(4'b0010, 32'h0000_5600, 1'b1);
    step(4'b0010, 32'h0000_5700, 1'b1);
    req = 4'b0010; out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_grant", 32'(grant), 32'h0);
    check_eq("midrst_pop", 32'(pop), 32'h0);
    check_eq("midrst_valid", 32'(out_valid), 32'h0);
    model_reset();
    req = 4'b0000;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    step(4'b1010, 32'h8800_9900, 1'b1);
    check_eq("rst_regrant", 32'(grant), 32'h2);
    for (int i = 0; i < 5; i++) step(4'b1010, 32'h8800_9900, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++)
      step(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
